// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register block.
// Line-level helpers live in i2c_line_sync; the FSM lives in i2c_target_regs.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK
    } i2c_state_e;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam int CNTW = 3;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers with registered bus-event detection.
// Events and sda_s are aligned: both reflect the same sampled instant.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_d;
    logic       sda_d;

    // Idle bus is high, so reset to 1 to avoid phantom edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync  <= 2'b11;
            sda_sync  <= 2'b11;
            scl_d     <= 1'b1;
            sda_d     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_sync  <= {scl_sync[0], scl_i};
            sda_sync  <= {sda_sync[0], sda_i};
            scl_d     <= scl_sync[1];
            sda_d     <= sda_sync[1];
            scl_rise  <= scl_sync[1] & ~scl_d;
            scl_fall  <= ~scl_sync[1] & scl_d;
            start_det <= scl_sync[1] & scl_d
                       & sda_d & ~sda_sync[1];
            stop_det  <= scl_sync[1] & scl_d
                       & ~sda_d & sda_sync[1];
        end
    end

    assign sda_s = sda_d;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with an auto-incrementing 8-bit register bank.
// Oversampled in clk; no clock stretching.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR  = 7'h2A,
    parameter int         NREGS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_oe,
    output logic [8*NREGS-1:0]       regs_flat,
    output logic                     wr_strobe,
    output logic [$clog2(NREGS)-1:0] wr_index,
    output logic                     busy
);

    localparam int PW = $clog2(NREGS);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_s;

    i2c_line_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_state_e      state, state_n;
    logic [1:0]      ph, ph_n;
    logic [CNTW-1:0] cnt, cnt_n;
    logic [6:0]      sh, sh_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic            ptr_set, ptr_set_n;
    logic            rw, rw_n;
    logic            oe_n;
    logic            wr_en;

    logic [7:0]      byte_in;
    logic [2:0]      rd_sel;
    logic            last;
    logic            shifting;
    logic            done;
    logic            addr_hit;

    assign byte_in  = {sh, sda_s};
    assign rd_sel   = 3'd7 - cnt;
    assign last     = (cnt == 3'd7);
    assign addr_hit = (byte_in[7:1] == ADDR)
                    && (byte_in[7:1] != 7'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        ph_n      = ph;
        cnt_n     = cnt;
        sh_n      = sh;
        ptr_n     = ptr;
        ptr_set_n = ptr_set;
        rw_n      = rw;
        oe_n      = sda_oe;
        wr_en     = 1'b0;
        shifting  = 1'b0;
        done      = 1'b0;

        if (stop_det) begin
            state_n   = ST_IDLE;
            oe_n      = 1'b0;
            ph_n      = 2'd0;
            cnt_n     = '0;
            ptr_set_n = 1'b0;
        end else if (start_det) begin
            // Repeated start keeps the pointer and its "set" flag.
            state_n = ST_ADDR;
            oe_n    = 1'b0;
            ph_n    = 2'd0;
            cnt_n   = '0;
            if (state == ST_IDLE) ptr_set_n = 1'b0;
        end else begin
            shifting = scl_rise && (state == ST_ADDR
                                 || state == ST_PTR
                                 || state == ST_WDATA);
            done = shifting && last;
            if (shifting) begin
                sh_n  = byte_in[6:0];
                cnt_n = cnt + 3'd1;
            end

            unique case (state)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (done) begin
                        ph_n = 2'd0;
                        if (addr_hit) begin
                            state_n = ST_ADDR_ACK;
                            rw_n    = byte_in[0];
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end
                end
                ST_PTR: begin
                    if (done) begin
                        ph_n      = 2'd0;
                        ptr_n     = byte_in[PW-1:0];
                        ptr_set_n = 1'b1;
                        state_n   = ST_PTR_ACK;
                    end
                end
                ST_WDATA: begin
                    if (done) begin
                        ph_n    = 2'd0;
                        wr_en   = 1'b1;
                        ptr_n   = ptr + PW'(1);
                        state_n = ST_WDATA_ACK;
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    // ph 0: drive ACK on first fall; ph 1: release.
                    if (scl_fall) begin
                        if (ph == 2'd0) begin
                            oe_n = ~ACK;
                            ph_n = 2'd1;
                        end else begin
                            oe_n  = 1'b0;
                            ph_n  = 2'd0;
                            cnt_n = '0;
                            if (state != ST_ADDR_ACK) begin
                                state_n = ST_WDATA;
                            end else if (rw) begin
                                state_n = ST_RDATA;
                                oe_n = ~regs_flat[{ptr, 3'd7}];
                            end else if (ptr_set) begin
                                state_n = ST_WDATA;
                            end else begin
                                state_n = ST_PTR;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        cnt_n = cnt + 3'd1;
                        if (last) begin
                            state_n = ST_RACK;
                            ph_n    = 2'd0;
                        end
                    end else if (scl_fall) begin
                        oe_n = ~regs_flat[{ptr, rd_sel}];
                    end
                end
                ST_RACK: begin
                    // ph 0 release, ph 1 sample, ph 2 resume reading.
                    unique case (ph)
                        2'd0: if (scl_fall) begin
                            oe_n = 1'b0;
                            ph_n = 2'd1;
                        end
                        2'd1: if (scl_rise) begin
                            if (sda_s == NACK) begin
                                state_n = ST_IDLE;
                                ph_n    = 2'd0;
                            end else begin
                                ptr_n = ptr + PW'(1);
                                ph_n  = 2'd2;
                            end
                        end
                        default: if (scl_fall) begin
                            state_n = ST_RDATA;
                            ph_n    = 2'd0;
                            cnt_n   = '0;
                            oe_n = ~regs_flat[{ptr, 3'd7}];
                        end
                    endcase
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph        <= 2'd0;
            cnt       <= '0;
            sh        <= '0;
            ptr       <= '0;
            ptr_set   <= 1'b0;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            regs_flat <= '0;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
            busy      <= 1'b0;
        end else begin
            ph        <= ph_n;
            cnt       <= cnt_n;
            sh        <= sh_n;
            ptr       <= ptr_n;
            ptr_set   <= ptr_set_n;
            rw        <= rw_n;
            sda_oe    <= oe_n;
            wr_strobe <= wr_en;
            if (wr_en) begin
                regs_flat[{ptr, 3'b000} +: 8] <= byte_in;
                wr_index <= ptr;
            end
            busy <= (state != ST_IDLE)
                 && (state != ST_ADDR || busy);
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: bit-banged I2C master against i2c_target_regs.
// Open-drain bus is modelled as a wired-AND of master and target.
module tb_i2c_target_regs;
    import i2c_pkg::*;

    localparam int Q = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic        sda_oe;
    logic        wr_strobe;
    logic        busy;
    logic [31:0] regs_flat;
    logic [1:0]  wr_index;
    logic        scl_i;
    logic        sda_i;

    assign scl_i = m_scl;
    assign sda_i = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regs #(
        .ADDR  (7'h2A),
        .NREGS (4)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_oe    (sda_oe),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_index  (wr_index),
        .busy      (busy)
    );

    int         n_chk = 0;
    int         n_err = 0;
    int         n_strobe = 0;
    int         n_oe = 0;
    int         n_busy = 0;
    logic [1:0] idx_log [16];

    always @(negedge clk) begin
        if (wr_strobe) begin
            idx_log[n_strobe[3:0]] = wr_index;
            n_strobe = n_strobe + 1;
        end
        if (sda_oe) n_oe = n_oe + 1;
        if (busy) n_busy = n_busy + 1;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h want %0h",
                     tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        m_sda = 1'b1;
        tick(Q);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;
        tick(Q);
        m_scl = 1'b1;
        tick(2 * Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        b = sda_i;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d,
                              output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d,
                             input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        send_bit(mack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         s_str;
        int         s_oe;
        int         s_busy;

        tick(4);
        check("rst_oe", 32'(sda_oe), 32'h0);
        check("rst_regs", regs_flat, 32'h0);
        check("rst_strobe", 32'(wr_strobe), 32'h0);
        check("rst_index", 32'(wr_index), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        tick(4);

        // Write 0xA5, 0x3C starting at reg1.
        s_str = n_strobe;
        i2c_start();
        write_byte(8'h54, ack);
        check("w_ack_addr", 32'(ack), 32'(ACK));
        write_byte(8'h01, ack);
        check("w_ack_ptr", 32'(ack), 32'(ACK));
        write_byte(8'hA5, ack);
        check("w_ack_d0", 32'(ack), 32'(ACK));
        write_byte(8'h3C, ack);
        check("w_ack_d1", 32'(ack), 32'(ACK));
        check("w_busy", 32'(busy), 32'h1);
        i2c_stop();
        tick(4);
        check("w_regs", regs_flat, 32'h003C_A500);
        check("w_nstrobe", 32'(n_strobe - s_str), 32'd2);
        check("w_idx0", 32'(idx_log[s_str[3:0]]), 32'd1);
        check("w_idx1", 32'(idx_log[4'(s_str + 1)]), 32'd2);
        check("w_busy_end", 32'(busy), 32'h0);

        // Preload reg3 and wrap to reg0.
        s_str = n_strobe;
        i2c_start();
        write_byte(8'h54, ack);
        write_byte(8'h03, ack);
        write_byte(8'h77, ack);
        check("p_ack_d0", 32'(ack), 32'(ACK));
        write_byte(8'h11, ack);
        check("p_ack_d1", 32'(ack), 32'(ACK));
        i2c_stop();
        tick(4);
        check("p_regs", regs_flat, 32'h773C_A511);
        check("p_idx0", 32'(idx_log[s_str[3:0]]), 32'd3);
        check("p_idx1", 32'(idx_log[4'(s_str + 1)]), 32'd0);

        // Read back via repeated start.
        i2c_start();
        write_byte(8'h54, ack);
        write_byte(8'h03, ack);
        i2c_start();
        write_byte(8'h55, ack);
        check("r_ack_addr", 32'(ack), 32'(ACK));
        read_byte(d, ACK);
        check("r_byte0", 32'(d), 32'h77);
        read_byte(d, NACK);
        check("r_byte1", 32'(d), 32'h11);
        check("r_oe_nack", 32'(sda_oe), 32'h0);
        i2c_stop();
        tick(4);
        check("r_oe", 32'(sda_oe), 32'h0);
        check("r_state", 32'(u_dut.state), 32'(ST_IDLE));
        check("r_busy", 32'(busy), 32'h0);

        // Address mismatch.
        s_str  = n_strobe;
        s_oe   = n_oe;
        s_busy = n_busy;
        i2c_start();
        write_byte(8'h40, ack);
        check("m_nack_addr", 32'(ack), 32'(NACK));
        write_byte(8'hFF, ack);
        check("m_nack_data", 32'(ack), 32'(NACK));
        i2c_stop();
        tick(4);
        check("m_oe_cycles", 32'(n_oe - s_oe), 32'd0);
        check("m_strobes", 32'(n_strobe - s_str), 32'd0);
        check("m_busy", 32'(n_busy - s_busy), 32'd0);

        // Abort a partial data byte with STOP.
        s_str = n_strobe;
        i2c_start();
        write_byte(8'h54, ack);
        write_byte(8'h00, ack);
        check("a_ack_ptr", 32'(ack), 32'(ACK));
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        i2c_stop();
        tick(4);
        check("a_regs", regs_flat, 32'h773C_A511);
        check("a_strobes", 32'(n_strobe - s_str), 32'd0);
        check("a_state", 32'(u_dut.state), 32'(ST_IDLE));
        check("a_busy", 32'(busy), 32'h0);

        // Reset while the target drives bit7 (0) of reg0.
        i2c_start();
        write_byte(8'h54, ack);
        write_byte(8'h00, ack);
        i2c_start();
        write_byte(8'h55, ack);
        check("x_drive", 32'(sda_oe), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("x_oe_async", 32'(sda_oe), 32'h0);
        check("x_regs", regs_flat, 32'h0);
        check("x_busy", 32'(busy), 32'h0);
        tick(2);
        rst = 1'b0;
        tick(4);
        i2c_stop();
        tick(4);

        s_str = n_strobe;
        i2c_start();
        write_byte(8'h54, ack);
        check("x_ack_addr", 32'(ack), 32'(ACK));
        write_byte(8'h02, ack);
        write_byte(8'h5A, ack);
        check("x_ack_data", 32'(ack), 32'(ACK));
        i2c_stop();
        tick(4);
        check("x_regs_new", regs_flat, 32'h005A_0000);
        check("x_strobes", 32'(n_strobe - s_str), 32'd1);
        check("x_idx", 32'(idx_log[s_str[3:0]]), 32'd2);

        $display("Result: errors=%0d of %0d checks",
                 n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (slave) with a small register file, sitting on the SDA/SCL bus directly downstream of `mod_I2C`, the bus master. It decodes the START, address, pointer and data frames that `mod_I2C` produces, ACKs them, and stores written bytes in an auto-incrementing register bank. It returns register contents on read transfers, so the master can be exercised end-to-end in simulation and on the board. All bus sampling is oversampled in the system clock domain; there is no SCL stretching.

## Interface
- `ADDR` — default 7'h2A — 7-bit target address matched after START.
- `NREGS` — default 4 — number of 8-bit registers; power of two, 2..16.
- `clk` — in, 1 — system clock; must be at least 8× SCL frequency.
- `rst` — in, 1 — reset; asynchronous, active-high.
- `scl_i` — in, 1 — SCL pin level, asynchronous.
- `sda_i` — in, 1 — SDA pin level, asynchronous.
- `sda_oe` — out, 1 — 1 pulls SDA low (open-drain); 0 releases. Top level ties `SDA = sda_oe ? 1'b0 : 1'bz`.
- `regs_flat` — out, 8·NREGS — register bank; reg k is bits [8k+7:8k].
- `wr_strobe` — out, 1 — one-cycle pulse when a data byte is committed.
- `wr_index` — out, log2(NREGS) — register written on `wr_strobe`.
- `busy` — out, 1 — high from an addressed START until STOP, NACK, or address mismatch.

## Operation
- Input conditioning:
  - `scl_i` and `sda_i` each pass through a 2-flop synchronizer plus one history flop.
  - Detected events: SCL rise, SCL fall, START (SDA fall while SCL high), STOP (SDA rise while SCL high).
- Bit sampling: data bits are sampled on SCL rise. SDA drive changes only on SCL fall.
- FSM states:
  - IDLE → ADDR on START.
  - ADDR: shift in 8 bits (7 address bits, then R/W). On match → ADDR_ACK; on mismatch → IDLE.
  - ADDR_ACK: drive ACK. Then go to RDATA if R/W=1, PTR if pointer not yet set in this transfer, else WDATA.
  - PTR: shift in 8 bits; pointer ← byte mod NREGS → PTR_ACK.
  - PTR_ACK → WDATA.
  - WDATA: shift in 8 bits → WDATA_ACK.
    - Entering WDATA_ACK writes reg[ptr], pulses `wr_strobe`, then ptr ← ptr+1 mod NREGS.
  - RDATA: shift out reg[ptr] MSB first → RACK.
  - RACK: sample the master ACK. ACK (0) → ptr+1 mod NREGS, back to RDATA. NACK (1) → IDLE.
- ACK drive: `sda_oe` asserts on the SCL fall after bit 8 and releases on the next SCL fall.
- Read drive: `sda_oe = ~bit` for the current bit. It is released after bit 8 so the master can drive the ACK bit.
- START in any state (repeated start) → ADDR. The pointer is kept; `sda_oe` releases immediately.
- STOP in any state → IDLE, `sda_oe` = 0.
- A partial byte interrupted by START or STOP is discarded; no write, no strobe.
- Address mismatch: stay in IDLE, ignoring all bits until the next START.
- General call (address 0) is not supported and is treated as a mismatch.

## Timing
- Reset values:
  - `sda_oe`=0, `regs_flat`=0, `wr_strobe`=0, `wr_index`=0, `busy`=0.
  - State IDLE, pointer 0.
- Reset mid-transfer releases SDA asynchronously in the same instant.
- Pin-to-event latency: 3 `clk` cycles (2 sync + 1 edge detect).
- `wr_strobe` and the `regs_flat` update occur in the same cycle, 1 cycle after the SCL-rise event of bit 8.
- `busy`:
  - Rises 1 cycle after the ADDR_ACK entry.
  - Falls 1 cycle after the STOP event, NACK sample, or mismatch.
- Simultaneous events:
  - START/STOP take priority over SCL edges in the same cycle.
  - A STOP after START with no bits in between → IDLE.

## Structure
- Package `i2c_pkg`:
  - FSM state enum.
  - Constants `ACK=1'b0` and `NACK=1'b1`.
  - Bit-counter width (3 bits, counts 0..7).
- Sub-module `i2c_line_sync`:
  - Contains the synchronizers and edge detection.
  - Outputs `scl_rise`, `scl_fall`, `start_det`, `stop_det`, `sda_s`.
  - Reused later by the master.
- The top level holds the FSM, shift register, pointer and register bank.

## Test plan
- Write: START, 0x54 (0x2A+W), 0x01, 0xA5, 0x3C, STOP.
  - Required: ACK on all 4 bytes; reg1=0xA5, reg2=0x3C.
  - Two `wr_strobe` pulses, with `wr_index` 1 then 2; `busy` drops after STOP.
- Read with repeated start: preload via write ptr 0x03 / 0x77 / 0x11 (wraps to reg0). Then START, 0x54, 0x03, rSTART, 0x55, master ACK, master NACK, STOP.
  - Required: target shifts out 0x77 then 0x11.
  - Final state IDLE; `sda_oe`=0.
- Address mismatch: START, 0x40, 0xFF, STOP.
  - Required: `sda_oe` never asserts; no `wr_strobe`; `busy` stays 0.
- Abort: START, 0x54, 0x00, 4 bits of 0xF0, then STOP.
  - Required: reg0 unchanged; no strobe; IDLE.
- Reset mid-read: assert `rst` while the target drives a 0 bit.
  - Required: `sda_oe`=0 immediately and all registers 0.
  - The next write transaction to 0x2A succeeds.
